// File: rtl/chnl_acc_ctrl_if.sv
// Beat and pixel-result handshake bundle between conv engine, controller and writer.
// Pure wiring, no latency.
// in_* carries partial-sum beats, out_* carries the completed pixel sum.
interface chnl_acc_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_last;

  // Controller side: accepts beats, presents pixel results.
  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_last
  );

  // Producer/consumer side: drives beats and the downstream ready.
  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_last
  );
endinterface

// File: rtl/chnl_acc_ctrl.sv
// Sequences accumulator clear/enable per channel group and hands completed pixel sums downstream.
// Start to first in_ready: 2 cycles; per pixel at full rate: G accumulate cycles + 1 output cycle.
// No beat is accepted while a pixel result is held; the result holds until out_ready.
module chnl_acc_ctrl #(
  parameter int GW = 8,
  parameter int PW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [GW-1:0] i_cfg_groups,
  input  logic [PW-1:0] i_cfg_pixels,
  chnl_acc_ctrl_if.slave bus,
  output logic          o_acc_en,
  output logic          o_acc_clr,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [GW-1:0] G_ONE = GW'(1);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_OUT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_grp_cnt;
  logic [PW-1:0] r_pix_cnt;
  logic [GW-1:0] r_groups_q;
  logic [PW-1:0] r_pixels_q;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_busy;
  logic          r_done;

  logic w_cfg_ok;
  logic w_grp_last;
  logic w_pix_last;
  logic w_out_hs;

  assign w_cfg_ok   = (i_cfg_groups != '0) && (i_cfg_pixels != '0);
  assign w_grp_last = (r_grp_cnt == (r_groups_q - G_ONE));
  assign w_pix_last = (r_pix_cnt == (r_pixels_q - P_ONE));
  assign w_out_hs   = r_out_valid & bus.out_ready;

  // Accumulator controls follow the live handshake; clear on job entry and between pixels only.
  assign o_acc_en  = bus.in_valid & r_in_ready;
  assign o_acc_clr = (r_state == S_CLEAR) | (w_out_hs & ~r_out_last);

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

  // Job sequencer; state-decoded outputs are registered alongside the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_grp_cnt   <= '0;
      r_pix_cnt   <= '0;
      r_groups_q  <= '0;
      r_pixels_q  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (w_cfg_ok) begin
              r_groups_q <= i_cfg_groups;
              r_pixels_q <= i_cfg_pixels;
              r_grp_cnt  <= '0;
              r_pix_cnt  <= '0;
              r_state    <= S_CLEAR;
            end else begin
              // Empty job: nothing to accumulate, report completion directly.
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          r_in_ready <= 1'b1;
          r_state    <= S_ACCUM;
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            if (w_grp_last) begin
              r_grp_cnt   <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              // pix_cnt is stable for the whole pixel, so out_last can be fixed here.
              r_out_last  <= w_pix_last;
              r_state     <= S_OUT;
            end else begin
              r_grp_cnt <= r_grp_cnt + G_ONE;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_pix_cnt  <= r_pix_cnt + P_ONE;
              r_in_ready <= 1'b1;
              r_state    <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chnl_acc_ctrl.sv
// Bench for chnl_acc_ctrl: directed scenarios plus randomized jobs against a job-level model.
// The model tracks beats, pixels and the expected sum per pixel with plain integers.
// A bench-side accumulator follows the DUT's acc_en/acc_clr to check held sums.
module tb_chnl_acc_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_g;
  logic [15:0] cfg_p;
  logic        acc_en;
  logic        acc_clr;
  logic        busy;
  logic        done;
  logic [7:0]  din;

  chnl_acc_ctrl_if u_if ();

  chnl_acc_ctrl #(.GW(8), .PW(16)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_cfg_groups (cfg_g),
    .i_cfg_pixels (cfg_p),
    .bus          (u_if.slave),
    .o_acc_en     (acc_en),
    .o_acc_clr    (acc_clr),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: job in progress, clear cycle pending, done pulse pending, beats/pixels so far.
  bit m_active, m_clear, m_done;
  int m_G, m_P, m_beats, m_pix, m_sum;
  int acc;
  int cyc, done_cyc, n_done;
  bit auto_drv;
  int p_valid, p_ready, p_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit e_ir, e_ov, e_ol, e_en, e_clr, s_en, s_clr;
    if (auto_drv) begin
      u_if.in_valid  = ($urandom_range(99) < p_valid);
      u_if.out_ready = ($urandom_range(99) < p_ready);
    end
    din = 8'($urandom);
    @(negedge clk);
    e_ir  = m_active && !m_clear && (m_beats < m_G);
    e_ov  = m_active && !m_clear && (m_beats == m_G);
    e_ol  = e_ov && (m_pix == m_P - 1);
    e_en  = e_ir && u_if.in_valid;
    e_clr = (m_active && m_clear) || (e_ov && u_if.out_ready && !e_ol);
    chk("in_ready",  32'(u_if.in_ready),  32'(e_ir));
    chk("out_valid", 32'(u_if.out_valid), 32'(e_ov));
    chk("out_last",  32'(u_if.out_last),  32'(e_ol));
    chk("acc_en",    32'(acc_en),         32'(e_en));
    chk("acc_clr",   32'(acc_clr),        32'(e_clr));
    chk("busy",      32'(busy),           32'(m_active || m_done));
    chk("done",      32'(done),           32'(m_done));
    if (e_ov) chk("pixel_sum", 32'(acc), 32'(m_sum));
    s_en  = acc_en;
    s_clr = acc_clr;
    if (done === 1'b1) begin
      done_cyc = cyc;
      n_done++;
    end
    @(posedge clk);
    if (s_clr) acc = 0;
    else if (s_en) acc += int'(din);
    if (rst) begin
      m_active = 0; m_clear = 0; m_done = 0;
      m_G = 0; m_P = 0; m_beats = 0; m_pix = 0; m_sum = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        if (cfg_g == 0 || cfg_p == 0) m_done = 1;
        else begin
          m_active = 1; m_clear = 1;
          m_G = int'(cfg_g); m_P = int'(cfg_p);
          m_beats = 0; m_pix = 0; m_sum = 0;
        end
      end
    end else if (m_clear) begin
      m_clear = 0;
    end else if (m_beats < m_G) begin
      if (u_if.in_valid) begin
        m_beats++;
        m_sum += int'(din);
      end
    end else if (u_if.out_ready) begin
      if (m_pix == m_P - 1) begin
        m_active = 0;
        m_done = 1;
      end else begin
        m_pix++;
        m_beats = 0;
        m_sum = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic launch(input int g, input int p, output int s);
    cfg_g = 8'(g);
    cfg_p = 16'(p);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    cfg_g = 8'($urandom);
    cfg_p = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n0 = n_done;
    for (int i = 0; i < budget && n_done == n0; i++) begin
      if (m_active && $urandom_range(99) < p_start) begin
        start = 1'b1;
        cfg_g = 8'($urandom_range(1, 9));
        cfg_p = 16'($urandom_range(1, 9));
      end
      step();
      start = 1'b0;
    end
    chk(tag, 32'(n_done - n0), 32'd1);
  endtask

  initial begin
    int s, snap;
    int pat [5] = '{1, 0, 1, 0, 1};
    rst = 1'b1; start = 1'b0; cfg_g = '0; cfg_p = '0; din = '0;
    u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
    auto_drv = 1'b0; p_valid = 100; p_ready = 100; p_start = 0;
    m_active = 0; m_clear = 0; m_done = 0;
    m_G = 0; m_P = 0; m_beats = 0; m_pix = 0; m_sum = 0;
    acc = 0; cyc = 0; done_cyc = -1; n_done = 0;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    step();

    // G=3, P=2 at full rate: done expected in cycle 10.
    auto_drv = 1'b1; p_valid = 100; p_ready = 100;
    launch(3, 2, s);
    wait_done(40, "g3p2_done");
    chk("g3p2_latency", 32'(done_cyc - s), 32'd10);
    step();

    // Same config with sparse beats and a stalled output.
    auto_drv = 1'b0;
    u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
    launch(3, 2, s);
    step();
    foreach (pat[i]) begin
      u_if.in_valid = pat[i][0];
      step();
    end
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("stall_held", 32'(u_if.out_valid), 32'd1);
    u_if.out_ready = 1'b1;
    step();
    auto_drv = 1'b1; p_valid = 100; p_ready = 100;
    wait_done(40, "stall_done");

    // G=1, P=4: done 9 cycles after CLEAR.
    launch(1, 4, s);
    wait_done(40, "g1p4_done");
    chk("g1p4_latency", 32'(done_cyc - s), 32'd10);

    // Empty job: done the very next cycle.
    launch(0, 5, s);
    wait_done(5, "zero_done");
    chk("zero_latency", 32'(done_cyc - s), 32'd1);
    step();

    // Start in ACCUM with another config is ignored.
    launch(3, 2, s);
    step();
    step();
    start = 1'b1; cfg_g = 8'd7; cfg_p = 16'd9;
    step();
    start = 1'b0;
    wait_done(40, "ign_done");
    chk("ign_latency", 32'(done_cyc - s), 32'd10);

    // Reset in the second ACCUM cycle aborts without a done pulse.
    launch(3, 2, s);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    snap = n_done;
    for (int i = 0; i < 12; i++) step();
    chk("rst_no_done", 32'(n_done - snap), 32'd0);
    launch(2, 3, s);
    wait_done(60, "post_rst_done");

    // Randomized jobs with random flow control and stray start pulses.
    p_start = 5;
    for (int j = 0; j < 40; j++) begin
      p_valid = $urandom_range(30, 100);
      p_ready = $urandom_range(30, 100);
      launch(($urandom_range(9) == 0) ? 0 : $urandom_range(1, 5), $urandom_range(1, 4), s);
      wait_done(400, "rand_done");
      if ($urandom_range(1) == 1) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
